// File: rtl/nanoV_pkg.sv
// Shared constants and helpers for the SPI bus monitor.
// Lane mapping and bit-count width used by the capture path.
package nanoV_pkg;

    localparam int CH_MOSI  = 0;
    localparam int CH_MISO  = 1;
    localparam int BITCNT_W = 8;

    typedef logic [BITCNT_W-1:0] bitcnt_t;

    localparam bitcnt_t BITCNT_MAX = '1;

    typedef enum logic [1:0] {
        CMT_NONE,
        CMT_FRAME,
        CMT_WORD
    } commit_e;

    function automatic bitcnt_t bitcnt_inc(input bitcnt_t c);
        return (c == BITCNT_MAX) ? c : c + bitcnt_t'(1);
    endfunction

endpackage

// File: rtl/spi_cap_lane.sv
// One captured SPI lane: shift register plus circular history array.
// Pointers and commit decisions come from the monitor top.
module spi_cap_lane
    import nanoV_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int HIST_DEPTH = 4
) (
    input  logic                          cpu_clk,
    input  logic                          rstn,
    input  logic                          i_shift,
    input  logic                          i_bit,
    input  logic                          i_clear,
    input  logic                          i_wr_en,
    input  logic                          i_wr_word,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_wr_ptr,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_rd_ptr,
    output logic [DATA_W-1:0]             o_rd_data
);

    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_hist [HIST_DEPTH];
    logic [DATA_W-1:0] w_sr_next;

    assign w_sr_next = {r_sr[DATA_W-2:0], i_bit};

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            r_sr <= '0;
        end else if (i_clear) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_sr_next;
        end
    end

    // A word commit stores the value including this cycle's bit.
    always_ff @(posedge cpu_clk) begin
        if (i_wr_en) begin
            r_hist[i_wr_ptr] <= i_wr_word ? w_sr_next : r_sr;
        end
    end

    assign o_rd_data = r_hist[i_rd_ptr];

endmodule

// File: rtl/spi_bus_monitor.sv
// SPI bus monitor: captures MOSI/MISO frames into a per-lane history
// with freeze, drop counting and registered history read-out.
module spi_bus_monitor
    import nanoV_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int HIST_DEPTH = 4,
    parameter int WORD_MODE  = 0
) (
    input  logic                                      cpu_clk,
    input  logic                                      rstn,
    input  logic                                      spi_select,
    input  logic                                      spi_mosi,
    input  logic                                      spi_miso,
    input  logic                                      freeze,
    input  logic [$clog2(HIST_DEPTH)-1:0]             view_sel,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic [DATA_W-1:0]                         view_data,
    output logic [7:0]                                view_bits,
    output logic [$clog2(HIST_DEPTH):0]               hist_count,
    output logic [15:0]                               frame_count,
    output logic [7:0]                                drop_count
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PTR_W:0] HIST_FULL = (PTR_W+1)'(HIST_DEPTH);
    localparam bitcnt_t        WORD_LAST = BITCNT_W'(DATA_W - 1);
    localparam bitcnt_t        WORD_BITS = BITCNT_W'(DATA_W);

    logic              r_prev_sel;
    bitcnt_t           r_bit_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    bitcnt_t           r_bits [HIST_DEPTH];

    logic              w_shift;
    logic              w_frame_end;
    commit_e           w_kind;
    logic              w_any;
    logic              w_commit;
    logic              w_drop;
    bitcnt_t           w_entry_bits;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_rd_valid;
    logic [DATA_W-1:0] w_sel_data;
    logic [DATA_W-1:0] w_lane_data [NUM_CH];

    assign w_shift     = ~spi_select;
    assign w_frame_end = spi_select & ~r_prev_sel;

    always_comb begin
        w_kind = CMT_NONE;
        if (WORD_MODE != 0 && w_shift && r_bit_cnt == WORD_LAST) begin
            w_kind = CMT_WORD;
        end else if (w_frame_end && r_bit_cnt != '0) begin
            w_kind = CMT_FRAME;
        end
    end

    assign w_any        = (w_kind != CMT_NONE);
    assign w_commit     = w_any & ~freeze;
    assign w_drop       = w_any & freeze;
    assign w_entry_bits = (w_kind == CMT_WORD) ? WORD_BITS : r_bit_cnt;

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            r_prev_sel  <= 1'b1;
            r_bit_cnt   <= '0;
            r_wr_ptr    <= '0;
            hist_count  <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            r_prev_sel <= spi_select;
            if (w_any) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= bitcnt_inc(r_bit_cnt);
            end
            if (w_commit) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                frame_count <= frame_count + 16'd1;
                if (hist_count != HIST_FULL) begin
                    hist_count <= hist_count + 1'b1;
                end
            end
            if (w_drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (w_commit) begin
            r_bits[r_wr_ptr] <= w_entry_bits;
        end
    end

    // Age 0 is the entry just behind the write pointer.
    assign w_rd_ptr   = r_wr_ptr - PTR_W'(1) - view_sel;
    assign w_rd_valid = ({1'b0, view_sel} < hist_count)
                      && (int'(ch_sel) < NUM_CH);

    always_comb begin
        w_sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == ch_sel) begin
                w_sel_data = w_lane_data[c];
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            view_data <= '0;
            view_bits <= '0;
        end else if (w_rd_valid) begin
            view_data <= w_sel_data;
            view_bits <= r_bits[w_rd_ptr];
        end else begin
            view_data <= '0;
            view_bits <= '0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic w_bit;
        assign w_bit = (c == CH_MISO) ? spi_miso : spi_mosi;

        spi_cap_lane #(
            .DATA_W     (DATA_W),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_lane (
            .cpu_clk   (cpu_clk),
            .rstn      (rstn),
            .i_shift   (w_shift & ~freeze),
            .i_bit     (w_bit),
            .i_clear   (w_any),
            .i_wr_en   (w_commit),
            .i_wr_word (w_kind == CMT_WORD),
            .i_wr_ptr  (r_wr_ptr),
            .i_rd_ptr  (w_rd_ptr),
            .o_rd_data (w_lane_data[c])
        );
    end

endmodule

// File: tb/tb_spi_bus_monitor.sv
// Bench for spi_bus_monitor: three configurations share one stimulus
// stream and are checked each cycle against a list-based history model.
module tb_spi_bus_monitor;

    logic        cpu_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_select = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  view_sel = 2'd0;
    logic        ch_sel = 1'b0;

    logic [31:0] vd  [3];
    logic [7:0]  vb  [3];
    logic [2:0]  hc  [3];
    logic [15:0] fcn [3];
    logic [7:0]  dcn [3];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    spi_bus_monitor #(.DATA_W(32), .NUM_CH(2), .HIST_DEPTH(4), .WORD_MODE(0)) u0 (
        .cpu_clk(cpu_clk), .rstn(rstn), .spi_select(spi_select),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .freeze(freeze),
        .view_sel(view_sel), .ch_sel(ch_sel), .view_data(vd[0]),
        .view_bits(vb[0]), .hist_count(hc[0]), .frame_count(fcn[0]),
        .drop_count(dcn[0]));

    spi_bus_monitor #(.DATA_W(32), .NUM_CH(2), .HIST_DEPTH(4), .WORD_MODE(1)) u1 (
        .cpu_clk(cpu_clk), .rstn(rstn), .spi_select(spi_select),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .freeze(freeze),
        .view_sel(view_sel), .ch_sel(ch_sel), .view_data(vd[1]),
        .view_bits(vb[1]), .hist_count(hc[1]), .frame_count(fcn[1]),
        .drop_count(dcn[1]));

    spi_bus_monitor #(.DATA_W(32), .NUM_CH(1), .HIST_DEPTH(4), .WORD_MODE(0)) u2 (
        .cpu_clk(cpu_clk), .rstn(rstn), .spi_select(spi_select),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .freeze(freeze),
        .view_sel(view_sel), .ch_sel(ch_sel), .view_data(vd[2]),
        .view_bits(vb[2]), .hist_count(hc[2]), .frame_count(fcn[2]),
        .drop_count(dcn[2]));

    // Model: per configuration, history is a newest-first list.
    int     wm  [3] = '{0, 1, 0};
    int     nch [3] = '{2, 2, 1};
    longint mv  [3][2];
    int     mn  [3];
    int     mp  [3] = '{1, 1, 1};
    longint hd  [3][4][2];
    int     hb  [3][4];
    int     hn  [3];
    int     fc  [3];
    int     dc  [3];
    longint ev_d [3];
    int     ev_b [3];

    task automatic model_step(input int m);
        int vs;
        int cs;
        int cb;
        vs = int'(view_sel);
        cs = int'(ch_sel);
        if (!rstn) begin
            mn[m] = 0; mv[m][0] = 0; mv[m][1] = 0;
            hn[m] = 0; fc[m] = 0; dc[m] = 0; mp[m] = 1;
            ev_d[m] = 0; ev_b[m] = 0;
            return;
        end
        if (cs < nch[m] && vs < hn[m]) begin
            ev_d[m] = hd[m][vs][cs];
            ev_b[m] = hb[m][vs];
        end else begin
            ev_d[m] = 0;
            ev_b[m] = 0;
        end
        cb = -1;
        if (!spi_select) begin
            mn[m]++;
            if (!freeze) begin
                mv[m][0] = (mv[m][0] * 2 + longint'(spi_mosi)) % (64'd1 << 32);
                mv[m][1] = (mv[m][1] * 2 + longint'(spi_miso)) % (64'd1 << 32);
            end
            if (wm[m] != 0 && mn[m] == 32) cb = 32;
        end else if (mp[m] == 0 && mn[m] > 0) begin
            cb = (mn[m] > 255) ? 255 : mn[m];
        end
        mp[m] = int'(spi_select);
        if (cb >= 0) begin
            if (freeze) begin
                if (dc[m] < 255) dc[m]++;
            end else begin
                for (int k = 3; k > 0; k--) begin
                    hd[m][k][0] = hd[m][k-1][0];
                    hd[m][k][1] = hd[m][k-1][1];
                    hb[m][k] = hb[m][k-1];
                end
                hd[m][0][0] = mv[m][0];
                hd[m][0][1] = mv[m][1];
                hb[m][0] = cb;
                if (hn[m] < 4) hn[m]++;
                fc[m] = (fc[m] + 1) % 65536;
            end
            mn[m] = 0; mv[m][0] = 0; mv[m][1] = 0;
        end
    endtask

    always @(posedge cpu_clk) begin
        for (int m = 0; m < 3; m++) model_step(m);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("view_data[%0d]", m), 64'(vd[m]), 64'(ev_d[m]));
                chk($sformatf("view_bits[%0d]", m), 64'(vb[m]), 64'(ev_b[m]));
                chk($sformatf("hist_count[%0d]", m), 64'(hc[m]), 64'(hn[m]));
                chk($sformatf("frame_count[%0d]", m), 64'(fcn[m]), 64'(fc[m]));
                chk($sformatf("drop_count[%0d]", m), 64'(dcn[m]), 64'(dc[m]));
            end
        end
    end

    task automatic send(input logic [127:0] mo, input logic [127:0] mi, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge cpu_clk);
            spi_select = 1'b0;
            spi_mosi = mo[i];
            spi_miso = mi[i];
        end
        @(negedge cpu_clk);
        spi_select = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic show(input int vs, input int cs);
        @(negedge cpu_clk);
        view_sel = 2'(vs);
        ch_sel = 1'(cs);
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        rstn = 1'b0;
        @(negedge cpu_clk);
        rstn = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge cpu_clk);
        rstn = 1'b1;
        chk_en = 1'b1;
        @(negedge cpu_clk);
        chk("rst view_data", 64'(vd[0]), 64'h0);
        chk("rst frame_count", 64'(fcn[0]), 64'h0);
        chk("rst hist_count", 64'(hc[1]), 64'h0);
        chk("rst drop_count", 64'(dcn[2]), 64'h0);

        send(128'hDEADBEEF, 128'h12345678, 32);
        show(0, 0);
        chk("f32 ch0 data", 64'(vd[0]), 64'hDEADBEEF);
        chk("f32 bits", 64'(vb[0]), 64'd32);
        chk("f32 frame_count", 64'(fcn[0]), 64'd1);
        chk("f32 word-mode frame_count", 64'(fcn[1]), 64'd1);
        chk("model f32 ch0", 64'(ev_d[0]), 64'hDEADBEEF);
        show(0, 1);
        chk("f32 ch1 data", 64'(vd[0]), 64'h12345678);
        chk("f32 ch1 word-mode", 64'(vd[1]), 64'h12345678);
        chk("one-lane ch1 zero", 64'(vd[2]), 64'h0);

        send(128'hABC, 128'h0, 12);
        show(0, 0);
        chk("f12 data", 64'(vd[0]), 64'h00000ABC);
        chk("f12 bits", 64'(vb[0]), 64'd12);

        send(128'hA50BADF00D, 128'h0, 40);
        show(0, 0);
        chk("f40 data", 64'(vd[0]), 64'h0BADF00D);
        chk("f40 bits", 64'(vb[0]), 64'd40);
        chk("f40 wm tail data", 64'(vd[1]), 64'h0D);
        chk("f40 wm tail bits", 64'(vb[1]), 64'd8);
        show(1, 0);
        chk("f40 wm word data", 64'(vd[1]), 64'hA50BADF0);

        send(128'h112222222233333333, 128'h0, 72);
        show(0, 0);
        chk("f72 wm bits0", 64'(vb[1]), 64'd8);
        chk("f72 wm data0", 64'(vd[1]), 64'h33);
        chk("f72 data", 64'(vd[0]), 64'h33333333);
        chk("f72 bits", 64'(vb[0]), 64'd72);
        show(1, 0);
        chk("f72 wm data1", 64'(vd[1]), 64'h22333333);
        chk("f72 wm bits1", 64'(vb[1]), 64'd32);
        show(2, 0);
        chk("f72 wm data2", 64'(vd[1]), 64'h11222222);
        chk("f72 wm frame_count", 64'(fcn[1]), 64'd7);

        send(128'hCAFEF00D12345678, 128'h0, 64);
        chk("f64 wm frame_count", 64'(fcn[1]), 64'd9);
        chk("f64 frame_count", 64'(fcn[0]), 64'd5);

        do_reset();
        send(128'h1, 128'h0, 1);
        show(0, 0);
        chk("pulse data", 64'(vd[0]), 64'h1);
        chk("pulse bits", 64'(vb[0]), 64'd1);
        show(1, 0);
        chk("beyond count data", 64'(vd[0]), 64'h0);
        chk("beyond count bits", 64'(vb[0]), 64'h0);

        do_reset();
        for (int k = 1; k <= 6; k++) send(128'(k), 128'h0, 8);
        for (int k = 0; k < 4; k++) begin
            show(k, 0);
            chk($sformatf("hist age %0d", k), 64'(vd[0]), 64'(6 - k));
        end
        chk("hist full", 64'(hc[0]), 64'd4);

        @(negedge cpu_clk);
        freeze = 1'b1;
        for (int k = 0; k < 300; k++) send(128'h3, 128'h0, 2);
        @(negedge cpu_clk);
        freeze = 1'b0;
        show(0, 0);
        chk("frozen drop_count", 64'(dcn[0]), 64'd255);
        chk("frozen frame_count", 64'(fcn[0]), 64'd6);
        chk("frozen newest", 64'(vd[0]), 64'd6);
        show(3, 0);
        chk("frozen oldest", 64'(vd[0]), 64'd3);

        do_reset();
        view_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            spi_select = 1'b0;
            spi_mosi = 1'(i);
        end
        @(negedge cpu_clk);
        rstn = 1'b0;
        @(negedge cpu_clk);
        rstn = 1'b1;
        spi_select = 1'b1;
        repeat (3) @(negedge cpu_clk);
        chk("midrst frame_count", 64'(fcn[0]), 64'd0);
        chk("midrst hist_count", 64'(hc[1]), 64'd0);
        chk("midrst view_data", 64'(vd[0]), 64'd0);
        chk("midrst view_bits", 64'(vb[0]), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
